// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x3 matrix keypad emulator and its code map.
package keypad_pkg;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned COL_W  = 3;

    localparam logic [CODE_W-1:0] KEY_HASH = 4'd11;
    localparam logic [CODE_W-1:0] KEY_STAR = 4'd12;
    localparam logic [CODE_W-1:0] KEY_NONE = 4'd15;

    // One-hot row strobes, top row first
    localparam logic [ROW_W-1:0] ROW_1 = 4'b1000;
    localparam logic [ROW_W-1:0] ROW_2 = 4'b0100;
    localparam logic [ROW_W-1:0] ROW_3 = 4'b0010;
    localparam logic [ROW_W-1:0] ROW_4 = 4'b0001;

    // One-hot column sense lines, left column first
    localparam logic [COL_W-1:0] COL_L = 3'b100;
    localparam logic [COL_W-1:0] COL_M = 3'b010;
    localparam logic [COL_W-1:0] COL_R = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/keypad_code_map.sv
// Combinational key code to {row strobe, column line, code valid} lookup.
module keypad_code_map
    import keypad_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [ROW_W-1:0]  row,
    output logic [COL_W-1:0]  col,
    output logic              code_ok
);

    always_comb begin
        row     = '0;
        col     = '0;
        code_ok = 1'b0;
        case (code)
            4'd1:     begin row = ROW_1; col = COL_L; code_ok = 1'b1; end
            4'd2:     begin row = ROW_1; col = COL_M; code_ok = 1'b1; end
            4'd3:     begin row = ROW_1; col = COL_R; code_ok = 1'b1; end
            4'd4:     begin row = ROW_2; col = COL_L; code_ok = 1'b1; end
            4'd5:     begin row = ROW_2; col = COL_M; code_ok = 1'b1; end
            4'd6:     begin row = ROW_2; col = COL_R; code_ok = 1'b1; end
            4'd7:     begin row = ROW_3; col = COL_L; code_ok = 1'b1; end
            4'd8:     begin row = ROW_3; col = COL_M; code_ok = 1'b1; end
            4'd9:     begin row = ROW_3; col = COL_R; code_ok = 1'b1; end
            KEY_STAR: begin row = ROW_4; col = COL_L; code_ok = 1'b1; end
            4'd0:     begin row = ROW_4; col = COL_M; code_ok = 1'b1; end
            KEY_HASH: begin row = ROW_4; col = COL_R; code_ok = 1'b1; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates a pressed key on a row-scan/column-sense keypad: follows the scanner's
// row strobes, holds the press for HOLD_SCANS visits, then idles GAP_SCANS scans.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned HOLD_SCANS  = 4,
    parameter int unsigned GAP_SCANS   = 2,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CODE_W-1:0] cmd_code,
    input  logic [ROW_W-1:0]  row_in,
    output logic [COL_W-1:0]  col_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned HOLD_W = $clog2(HOLD_SCANS + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_SCANS + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_SCANS);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_SCANS);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_SCANS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    state_t             state;
    logic [ROW_W-1:0]   key_row;
    logic [COL_W-1:0]   key_col;
    logic               hit_d;
    logic               row1_d;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TO_W-1:0]    to_cnt;

    logic [ROW_W-1:0]   map_row;
    logic [COL_W-1:0]   map_col;
    logic               map_ok;

    keypad_code_map u_code_map (
        .code    (cmd_code),
        .row     (map_row),
        .col     (map_col),
        .code_ok (map_ok)
    );

    // Exact compare: idle (0000) or multi-hot row drive never matches a one-hot key row
    logic hit;
    logic visit;
    logic row1_hit;
    logic gap_visit;
    logic to_expire;

    assign hit       = (row_in == key_row);
    assign visit     = hit && !hit_d;
    assign row1_hit  = (row_in == ROW_1);
    assign gap_visit = row1_hit && !row1_d;
    assign to_expire = (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            key_row   <= '0;
            key_col   <= '0;
            hit_d     <= 1'b0;
            row1_d    <= 1'b0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
            cmd_ready <= 1'b1;
            col_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            row1_d <= row1_hit;
            case (state)
                IDLE: begin
                    col_out <= '0;
                    if (cmd_valid && cmd_ready) begin
                        if (map_ok) begin
                            key_row   <= map_row;
                            key_col   <= map_col;
                            hit_d     <= 1'b0;
                            hold_cnt  <= '0;
                            gap_cnt   <= '0;
                            to_cnt    <= '0;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                            state     <= PRESS;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                PRESS: begin
                    hit_d <= hit;
                    if (!visit && to_expire) begin
                        to_cnt    <= '0;
                        col_out   <= '0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        err       <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        if (visit) begin
                            to_cnt <= '0;
                            if (hold_cnt != HOLD_MAX) begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                        // Release only once the last held strobe has ended
                        if (hold_cnt == HOLD_MAX && !hit) begin
                            col_out <= '0;
                            state   <= GAP;
                        end else begin
                            col_out <= hit ? key_col : '0;
                        end
                    end
                end

                GAP: begin
                    col_out <= '0;
                    if (gap_visit) begin
                        to_cnt <= '0;
                        if (gap_cnt == GAP_LAST) begin
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else if (gap_cnt != GAP_MAX) begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end else if (to_expire) begin
                        to_cnt    <= '0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        err       <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                default: begin
                    col_out   <= '0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
Behavioural/synthesizable model of the physical 4x3 matrix keypad: the other end of the row-scan/column-sense keypad interface used by our scanner blocks.
- Accepts key-press commands over a valid/ready handshake.
- Watches the one-hot row strobes driven by a scanner and drives the column lines exactly as a pressed key would.
- Holds each press for a programmable number of scans, then releases.
- Serves as a bench driver and an on-board self-test source for the keypad scanner path.

Parameters:
- HOLD_SCANS, 4: number of visits of the key's row during which the key is reported pressed (min 1).
- GAP_SCANS, 2: number of row-1000 visits with all columns released before the next command is accepted (min 1).
- TIMEOUT_CYC, 200000: clk cycles without a counted row visit before the operation aborts.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  key-press request valid
- cmd_ready  out  1  emulator can accept a command
- cmd_code  in  4  key code: 0-9 digits, 11 = '#', 12 = '*'; 10, 13, 14, 15 invalid
- row_in  in  4  scanner row drive, one-hot: 1000 = keys 1/2/3, 0100 = 4/5/6, 0010 = 7/8/9, 0001 = */0/#
- col_out  out  3  column sense, one-hot when the pressed key's row is strobed: 100 = 1/4/7/*, 010 = 2/5/8/0, 001 = 3/6/9/#; 000 = no key
- busy  out  1  press or release gap in progress
- done  out  1  one-cycle pulse when a command completes normally
- err  out  1  one-cycle pulse for an invalid code or a timeout

Behaviour:
- Reset values: cmd_ready=1, col_out=000, busy=0, done=0, err=0, state IDLE, all counters 0.
- Reset mid-operation returns to IDLE on that edge; col_out=000 from the next cycle.
- All outputs are registered.
- FSM states: IDLE, PRESS, GAP.
- IDLE:
  - cmd_ready=1.
  - On the edge where cmd_valid & cmd_ready: latch key_row and key_col from cmd_code.
  - Valid code -> PRESS at T+1 with busy=1 and cmd_ready=0.
  - Invalid code -> err=1 at T+1, stay IDLE, col_out remains 000.
- PRESS:
  - col_out(t+1) = key_col when row_in(t) == key_row exactly; otherwise 000.
  - row_in that is 0000 or not one-hot always yields 000.
  - hit = (row_in == key_row). A visit is a rising hit (hit & !hit_d); hit_d is cleared on entry to PRESS.
  - After HOLD_SCANS visits, on the first cycle row_in != key_row: go to GAP and force col_out=000.
  - The final visit's strobe period is always completed; the column never drops mid-strobe.
- GAP:
  - col_out=000.
  - A visit is a rising (row_in == 1000).
  - After GAP_SCANS visits: go to IDLE, done=1 for one cycle, cmd_ready=1 in the same cycle.
- Timeout:
  - A counter counts clk cycles in PRESS/GAP and clears on each counted visit.
  - Reaching TIMEOUT_CYC: go to IDLE, err=1 for one cycle, col_out=000, done stays 0.
- cmd_valid while cmd_ready=0 is ignored; the command is not queued.
- Counter widths are sized with $clog2(param+1). Counters saturate and never wrap.
- done and err are never asserted together.
- Back-to-back commands: a new command can be accepted in the same cycle done is asserted.

Decomposition:
- Package keypad_pkg holds:
  - key code constants (KEY_STAR=12, KEY_HASH=11, KEY_NONE=15);
  - row one-hot constants ROW_1..ROW_4;
  - column one-hot constants COL_L, COL_M, COL_R;
  - the FSM state enum.
- Sub-module keypad_code_map: purely combinational mapping cmd_code -> {row[3:0], col[2:0], code_ok}. It is shared with the scanner's decode table for consistency.

Test Plan:
1. Press 5, HOLD_SCANS=4; row_in rotates 1000→0100→0010→0001 every 4 clk -> col_out=010 exactly one cycle after each 0100 strobe (4 times), 000 elsewhere; done pulses after 2 further 1000 visits.
2. Press 12 ('*') then immediately 11 ('#') issued on the done cycle -> col_out=100 on row 0001 strobes, then 001 on row 0001 strobes; no gap cycle lost on cmd_ready.
3. cmd_code=10 with cmd_valid -> err=1 one cycle after handshake, busy stays 0, col_out=000, cmd_ready stays 1.
4. Press 7 with row_in stuck at 1000, TIMEOUT_CYC=50 -> col_out stays 000; err=1 exactly 50 cycles after entering PRESS; return to IDLE.
5. Press 1, assert rst for 1 cycle during a 1000 strobe while col_out=100 -> col_out=000, busy=0, cmd_ready=1 on the cycle after reset; no done or err.
6. Press 0 while row_in=0101 and 0000 are injected -> col_out=000 on those cycles; visits counted only on clean 0001 entries.
